// File: rtl/cfu_init_pkg.sv
// ---------------------------------------------------------------------------
// cfu_init_pkg -- shared types for the CFU command initiator | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cfu_init_pkg;

  localparam int CFU_FID_W  = 10;
  localparam int CFU_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } cfu_state_e;

  typedef struct packed {
    logic [CFU_FID_W-1:0]  fid;
    logic [CFU_DATA_W-1:0] op0;
    logic [CFU_DATA_W-1:0] op1;
  } cfu_req_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cfu_req_fifo.sv
// ---------------------------------------------------------------------------
// cfu_req_fifo -- DEPTH-entry request FIFO, wrap-bit pointers | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cfu_req_fifo
  import cfu_init_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     i_push,
  input  cfu_req_t i_data,
  input  logic     i_pop,
  output cfu_req_t o_head,
  output logic     o_full,
  output logic     o_empty
);

  localparam int            c_AW      = $clog2(DEPTH);
  localparam logic [c_AW:0] c_PTR_ONE = (c_AW + 1)'(1);

  cfu_req_t      r_mem [DEPTH];
  logic [c_AW:0] r_wr_ptr;
  logic [c_AW:0] r_rd_ptr;

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr[c_AW-1:0]] <= i_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
    end
  end

  // Same index with differing wrap bits means the writer has lapped the reader.
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                   (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
  assign o_head  = r_mem[r_rd_ptr[c_AW-1:0]];

endmodule

`default_nettype wire

// File: rtl/cfu_cmd_initiator.sv
// ---------------------------------------------------------------------------
// cfu_cmd_initiator -- buffered CFU cmd/rsp initiator with timeout | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cfu_cmd_initiator
  import cfu_init_pkg::*;
#(
  parameter int                    DEPTH          = 4,
  parameter int                    TIMEOUT_CYCLES = 16,
  parameter logic [CFU_DATA_W-1:0] TIMEOUT_VALUE  = 32'hDEAD_BEEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [CFU_FID_W-1:0]  req_function_id,
  input  logic [CFU_DATA_W-1:0] req_op0,
  input  logic [CFU_DATA_W-1:0] req_op1,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [CFU_DATA_W-1:0] res_data,
  output logic                  res_timeout,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [CFU_FID_W-1:0]  cmd_payload_function_id,
  output logic [CFU_DATA_W-1:0] cmd_payload_inputs_0,
  output logic [CFU_DATA_W-1:0] cmd_payload_inputs_1,
  input  logic                  rsp_valid,
  output logic                  rsp_ready,
  input  logic [CFU_DATA_W-1:0] rsp_payload_outputs_0,
  output logic                  busy,
  output logic [15:0]           timeout_count,
  output logic [15:0]           stale_count
);

  localparam int              c_TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_TW-1:0] c_TMR_LAST = c_TW'(TIMEOUT_CYCLES - 1);
  localparam logic [c_TW-1:0] c_TMR_ONE  = c_TW'(1);

  cfu_state_e            r_state;
  cfu_state_e            w_next_state;
  cfu_req_t              r_cmd;
  cfu_req_t              w_fifo_head;
  cfu_req_t              w_req;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_cmd_fire;
  logic                  w_rsp_fire;
  logic                  w_capture;
  logic                  w_timeout;
  logic                  w_stale;
  logic [c_TW-1:0]       r_timer;
  logic [CFU_DATA_W-1:0] r_res_data;
  logic                  r_res_timeout;
  logic [15:0]           r_timeout_count;
  logic [15:0]           r_stale_count;

  assign w_req  = '{fid: req_function_id, op0: req_op0, op1: req_op1};
  assign w_push = req_valid && !w_fifo_full;

  cfu_req_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .i_push  (w_push),
    .i_data  (w_req),
    .i_pop   (w_pop),
    .o_head  (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // Handshake outputs decode straight from the state register so reset clears them at once.
  assign req_ready  = !w_fifo_full;
  assign cmd_valid  = (r_state == ISSUE);
  assign res_valid  = (r_state == DONE);
  assign rsp_ready  = (r_state != DONE);
  assign busy       = (r_state != IDLE) || !w_fifo_empty;
  assign w_cmd_fire = cmd_valid && cmd_ready;
  assign w_rsp_fire = rsp_valid && rsp_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_capture    = 1'b0;
    w_timeout    = 1'b0;
    w_stale      = 1'b0;
    case (r_state)
      IDLE: begin
        w_stale = w_rsp_fire;
        if (!w_fifo_empty) begin
          w_pop        = 1'b1;
          w_next_state = ISSUE;
        end
      end
      ISSUE: begin
        if (w_cmd_fire) begin
          if (rsp_valid) begin
            w_capture    = 1'b1;
            w_next_state = DONE;
          end else begin
            w_next_state = WAIT;
          end
        end else begin
          w_stale = w_rsp_fire;
        end
      end
      WAIT: begin
        if (rsp_valid) begin
          w_capture    = 1'b1;
          w_next_state = DONE;
        end else if (r_timer == c_TMR_LAST) begin
          w_timeout    = 1'b1;
          w_next_state = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          if (!w_fifo_empty) begin
            w_pop        = 1'b1;
            w_next_state = ISSUE;
          end else begin
            w_next_state = IDLE;
          end
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timer <= '0;
    end else if (w_cmd_fire) begin
      r_timer <= '0;
    end else if (r_state == WAIT) begin
      r_timer <= r_timer + c_TMR_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cmd           <= '0;
      r_res_data      <= '0;
      r_res_timeout   <= 1'b0;
      r_timeout_count <= '0;
      r_stale_count   <= '0;
    end else begin
      if (w_pop) begin
        r_cmd <= w_fifo_head;
      end
      if (w_capture) begin
        r_res_data    <= rsp_payload_outputs_0;
        r_res_timeout <= 1'b0;
      end
      if (w_timeout) begin
        r_res_data      <= TIMEOUT_VALUE;
        r_res_timeout   <= 1'b1;
        r_timeout_count <= sat_inc16(r_timeout_count);
      end
      if (w_stale) begin
        r_stale_count <= sat_inc16(r_stale_count);
      end
    end
  end

  assign cmd_payload_function_id = r_cmd.fid;
  assign cmd_payload_inputs_0    = r_cmd.op0;
  assign cmd_payload_inputs_1    = r_cmd.op1;
  assign res_data                = r_res_data;
  assign res_timeout             = r_res_timeout;
  assign timeout_count           = r_timeout_count;
  assign stale_count             = r_stale_count;

endmodule

`default_nettype wire
